aes_inv_cipher_iter: RTL and testbench

//  Iterative AES inverse cipher. One round datapath runs NR times on a held state register.
//  Per-round op order: InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns; the final round omits InvMixColumns.

---
 rtl/aes_inv_cipher_iter_if.sv | 32 +++
 rtl/aes_inv_cipher_iter.sv | 175 +++++++++++++++++
 tb/tb_aes_inv_cipher_iter.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake/bus bundle for aes_inv_cipher_iter.
// Carries three groups of signals:
//   - ciphertext input channel: in_valid, in_ready, in_data
//   - plaintext output channel: out_valid, out_ready, out_data
//   - round-key lookup: round_key_idx (from the cipher), round_key (returned the same cycle)
// It also carries the busy status flag.
// Modports:
//   - master: the environment side (ciphertext source, key store, plaintext sink)
//   - slave:  the cipher itself
interface aes_inv_cipher_iter_if #(
  parameter int IDX_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [127:0]     in_data;
  logic [IDX_W-1:0] round_key_idx;
  logic [127:0]     round_key;
  logic             out_valid;
  logic             out_ready;
  logic [127:0]     out_data;
  logic             busy;

  modport master (
    output in_valid, in_data, round_key, out_ready,
    input  in_ready, round_key_idx, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, round_key, out_ready,
    output in_ready, round_key_idx, out_valid, out_data, busy
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher (AES-128/192/256 selected by NR).
// One inverse round is evaluated per clock on a held 128-bit state register.
// The initial AddRoundKey uses key NR. Rounds NR-1..1 apply the full inverse round.
// The last round (key 0) skips InvMixColumns.
// Round keys come from an external store: round_key_idx selects the key, and
// round_key is expected back combinationally in the same cycle.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous reset, active low
//   bus   aes_inv_cipher_iter_if.slave, which carries:
//     - ciphertext in:  in_valid / in_ready / in_data
//     - plaintext out:  out_valid / out_ready / out_data
//     - key lookup:     round_key_idx / round_key
//     - status:         busy (high while rounds are in flight)
// Byte 0 of every 128-bit block sits in [127:120]. The state is column-major
// (byte i is row i%4, column i/4).
module aes_inv_cipher_iter #(
  parameter int NR    = 10,
  parameter int IDX_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_iter_if.slave bus
);

  if (!(NR == 10 || NR == 12 || NR == 14) || (2 ** IDX_W) <= NR) begin : gParamCheck
    $fatal(1, "aes_inv_cipher_iter: NR must be 10/12/14 and 2**IDX_W > NR");
  end

  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} fsm_t;

  fsm_t             fsmState, nextFsm;
  logic [IDX_W-1:0] rnd;
  logic [IDX_W-1:0] keyIdx;
  logic [127:0]     stateReg;
  logic [127:0]     outDataReg;
  logic             outValidReg;
  logic             inReady;
  logic             accept;
  logic [127:0]     roundOut;

  function automatic logic [7:0] gMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0.
  function automatic logic [7:0] gInv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gMul(sq, sq);
      acc = gMul(acc, sq);
    end
    return acc;
  endfunction

  // Undo the S-box affine map first, then invert in GF(2^8).
  function automatic logic [7:0] invSbox(input logic [7:0] b);
    logic [7:0] t;
    t = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gInv(t);
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [127:0] invShiftRows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[8*(15-(r+4*c)) +: 8] = s[8*(15-(r+4*((c+4-r)%4))) +: 8];
    return o;
  endfunction

  function automatic logic [127:0] invSubBytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*(15-i) +: 8] = invSbox(s[8*(15-i) +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] invMixColumns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = gMul(a0, 8'h0e) ^ gMul(a1, 8'h0b) ^ gMul(a2, 8'h0d) ^ gMul(a3, 8'h09);
      o[8*(14-4*c) +: 8] = gMul(a0, 8'h09) ^ gMul(a1, 8'h0e) ^ gMul(a2, 8'h0b) ^ gMul(a3, 8'h0d);
      o[8*(13-4*c) +: 8] = gMul(a0, 8'h0d) ^ gMul(a1, 8'h09) ^ gMul(a2, 8'h0e) ^ gMul(a3, 8'h0b);
      o[8*(12-4*c) +: 8] = gMul(a0, 8'h0b) ^ gMul(a1, 8'h0d) ^ gMul(a2, 8'h09) ^ gMul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Shared by RUN and LAST; only RUN follows it with InvMixColumns.
  assign roundOut = invSubBytes(invShiftRows(stateReg)) ^ bus.round_key;
  assign accept   = bus.in_valid & inReady;

  always_ff @(posedge clk) begin
    if (!rst_n) fsmState <= IDLE;
    else        fsmState <= nextFsm;
  end

  // DONE indexes key NR, so a pass-through accept sees the same key as IDLE.
  always_comb begin
    nextFsm = fsmState;
    keyIdx  = IDX_W'(NR);
    inReady = 1'b0;
    unique case (fsmState)
      IDLE: begin
        inReady = 1'b1;
        if (bus.in_valid) nextFsm = RUN;
      end
      RUN: begin
        keyIdx = rnd;
        if (rnd == IDX_W'(1)) nextFsm = LAST;
      end
      LAST: begin
        keyIdx  = '0;
        nextFsm = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          inReady = 1'b1;
          nextFsm = bus.in_valid ? RUN : IDLE;
        end
      end
      default: nextFsm = IDLE;
    endcase
  end

  // Round state: load on accept, one inverse round per cycle in RUN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg    <= '0;
      rnd         <= '0;
      outDataReg  <= '0;
      outValidReg <= 1'b0;
    end else begin
      if (accept) begin
        stateReg <= bus.in_data ^ bus.round_key;
        rnd      <= IDX_W'(NR - 1);
      end else if (fsmState == RUN) begin
        stateReg <= invMixColumns(roundOut);
        rnd      <= rnd - IDX_W'(1);
      end
      // Output register: loaded in LAST, held until popped.
      if (fsmState == LAST) begin
        outDataReg  <= roundOut;
        outValidReg <= 1'b1;
      end else if (fsmState == DONE && bus.out_ready) begin
        outValidReg <= 1'b0;
      end
    end
  end

  assign bus.in_ready      = inReady;
  assign bus.round_key_idx = keyIdx;
  assign bus.out_valid     = outValidReg;
  assign bus.out_data      = outDataReg;
  assign bus.busy          = (fsmState == RUN) || (fsmState == LAST);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Testbench for aes_inv_cipher_iter.
// Plaintexts are encrypted with a forward AES model kept in this bench. The
// resulting ciphertext is fed to the cipher, and the plaintext is expected back.
// Known-answer blocks are also driven for NR=10, 12 and 14.
module tb_aes_inv_cipher_iter;

  localparam int NRM = 10;
  localparam logic [127:0] PT_KAT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;
  bit goBig = 1'b0;
  bit randReady = 1'b0;

  logic [7:0]   sbox [0:255];
  logic [127:0] rkM [0:15];
  logic [127:0] expQ [$];
  int           accQ [$];

  aes_inv_cipher_iter_if #(.IDX_W(4)) m ();
  aes_inv_cipher_iter #(.NR(NRM), .IDX_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(m.slave));
  assign m.round_key = rkM[m.round_key_idx];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkEq(input string name, input logic [127:0] act, input logic [127:0] exp);
    nCmp++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    nCmp++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic failNow(input string name);
    nCmp++;
    nFail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // ---------------- forward AES reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmulT(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: brute-force inverse, then the affine map.
  task automatic buildSbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmulT(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      sbox[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
  endfunction

  task automatic expandKey(input logic [255:0] key, input int nk, output logic [127:0] rk [0:15]);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nk+7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk[r] = (r <= nk + 6) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] rk [0:15], input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int row = 0; row < 4; row++)
        for (int col = 0; col < 4; col++)
          s[row+4*col] = t[row+4*((col+row)%4)];
      if (r != nr) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[r][127-8*i -: 8];
    end
    o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- NR=12 / NR=14 known-answer instances ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : gBig
    localparam int NRG = 12 + 2*gi;
    localparam logic [255:0] KEYG = (gi == 0)
      ? {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}
      : 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CTG = (gi == 0) ? 128'hdda97ca4864cdfe06eaf70a0ec0d7191
                                             : 128'h8ea2b7ca516745bfeafc49904b496089;
    aes_inv_cipher_iter_if #(.IDX_W(4)) g ();
    aes_inv_cipher_iter #(.NR(NRG), .IDX_W(4)) dutBig (.clk(clk), .rst_n(rst_n), .bus(g.slave));
    logic [127:0] rk [0:15];
    bit done = 1'b0;
    int lat;
    assign g.round_key = rk[g.round_key_idx];

    initial begin
      g.in_valid = 1'b0; g.in_data = '0; g.out_ready = 1'b1;
      wait (goBig == 1'b1);
      expandKey(KEYG, NRG - 6, rk);
      @(posedge clk); #1;
      g.in_valid = 1'b1; g.in_data = CTG;
      checkInt($sformatf("kat%0d_in_ready", NRG), int'(g.in_ready), 1);
      @(posedge clk); #1;
      g.in_valid = 1'b0; g.in_data = '1;
      lat = 0;
      while (!g.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      checkInt($sformatf("kat%0d_latency", NRG), lat, NRG);
      checkEq($sformatf("kat%0d_out_data", NRG), g.out_data, PT_KAT);
      done = 1'b1;
    end
  end

  // ---------------- monitor / scoreboard for the NR=10 instance ----------------
  int idxCnt = 0;
  bit prevValid = 1'b0;
  bit prevReady = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      accQ.delete();
      idxCnt = 0; prevValid = 1'b0; prevReady = 1'b0;
    end else begin
      // Key index seen at accept, then NR-1 .. 0 over the following NR cycles.
      if (m.in_valid && m.in_ready) begin
        accQ.push_back(cyc + 1);
        checkInt("idx_accept", int'(m.round_key_idx), NRM);
        checkInt("busy_accept", int'(m.busy), 0);
        idxCnt = NRM;
      end else if (idxCnt > 0) begin
        idxCnt--;
        checkInt("idx_seq", int'(m.round_key_idx), idxCnt);
        checkInt("busy_run", int'(m.busy), 1);
      end
      if (m.out_valid) begin
        if (!prevValid) begin
          if (accQ.size() == 0) failNow("latency_no_accept");
          else checkInt("latency", cyc - accQ.pop_front(), NRM);
        end
        checkInt("in_ready_done", int'(m.in_ready), int'(m.out_ready));
        if (expQ.size() == 0) failNow("unexpected_out_valid");
        else begin
          checkEq("out_data", m.out_data, expQ[0]);
          if (m.out_ready) void'(expQ.pop_front());
        end
      end else if (prevValid && !prevReady) begin
        failNow("out_valid_retracted");
      end
      prevValid = m.out_valid;
      prevReady = m.out_ready;
    end
  end

  always @(posedge clk) begin
    #1;
    if (randReady) m.out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver ----------------
  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt, input bit hold);
    int n = 0;
    m.in_valid = 1'b1; m.in_data = ct;
    expQ.push_back(pt);
    @(negedge clk);
    while (!m.in_ready && n < 3000) begin @(negedge clk); n++; end
    cycle();
    if (n >= 3000) begin
      failNow("accept_timeout");
      void'(expQ.pop_back());
      m.in_valid = 1'b0;
    end else if (!hold) begin
      m.in_valid = 1'b0;
      m.in_data = rand128();
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || m.out_valid) && n < 3000) begin cycle(); n++; end
    if (n >= 3000) begin failNow("drain_timeout"); expQ.delete(); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    int n;
    rst_n = 1'b0;
    m.in_valid = 1'b0; m.in_data = '0; m.out_ready = 1'b1;
    buildSbox();
    expandKey(KEY128, 4, rkM);
    repeat (2) cycle();
    checkInt("rst_out_valid", int'(m.out_valid), 0);
    checkEq("rst_out_data", m.out_data, 128'h0);
    checkInt("rst_busy", int'(m.busy), 0);
    checkInt("rst_in_ready", int'(m.in_ready), 1);
    checkInt("rst_idx", int'(m.round_key_idx), NRM);
    rst_n = 1'b1;

    // NR=12 and NR=14 known-answer blocks run on their own instances.
    goBig = 1'b1;
    n = 0;
    while (!(gBig[0].done && gBig[1].done) && n < 200) begin cycle(); n++; end
    if (n >= 200) failNow("kat_big_timeout");

    // AES-128 known-answer block.
    send(CT128, PT_KAT, 1'b0);
    waitDrain();

    // Output held under back-pressure, then a single pop.
    m.out_ready = 1'b0;
    pt = rand128();
    send(encrypt(pt, rkM, NRM), pt, 1'b0);
    n = 0;
    while (!m.out_valid && n < 50) begin cycle(); n++; end
    if (n >= 50) failNow("bp_valid_timeout");
    repeat (20) cycle();
    m.out_ready = 1'b1;
    cycle();
    checkInt("release_out_valid", int'(m.out_valid), 0);
    checkInt("release_in_ready", int'(m.in_ready), 1);
    checkInt("release_busy", int'(m.busy), 0);
    waitDrain();

    // Garbage in_valid pulse while rounds are in flight.
    pt = rand128();
    send(encrypt(pt, rkM, NRM), pt, 1'b0);
    repeat (3) cycle();
    m.in_valid = 1'b1; m.in_data = rand128();
    cycle();
    m.in_valid = 1'b0;
    waitDrain();

    // Back-to-back: in_valid held high, four blocks under one key.
    send(CT128, PT_KAT, 1'b1);
    for (int k = 0; k < 3; k++) begin
      pt = rand128();
      send(encrypt(pt, rkM, NRM), pt, (k < 2) ? 1'b1 : 1'b0);
    end
    waitDrain();

    // Reset in the fifth RUN cycle abandons the block.
    pt = rand128();
    send(encrypt(pt, rkM, NRM), pt, 1'b0);
    repeat (4) cycle();
    rst_n = 1'b0;
    expQ.delete();
    cycle();
    checkInt("midrst_out_valid", int'(m.out_valid), 0);
    checkEq("midrst_out_data", m.out_data, 128'h0);
    checkInt("midrst_busy", int'(m.busy), 0);
    checkInt("midrst_in_ready", int'(m.in_ready), 1);
    rst_n = 1'b1;
    send(CT128, PT_KAT, 1'b0);
    waitDrain();

    // Random keys, random plaintexts, random gaps and random out_ready.
    for (int kk = 0; kk < 2; kk++) begin
      expandKey({rand128(), 128'h0}, 4, rkM);
      randReady = 1'b1;
      for (int b = 0; b < 6; b++) begin
        repeat ($urandom_range(0, 3)) cycle();
        pt = rand128();
        send(encrypt(pt, rkM, NRM), pt, 1'b0);
      end
      waitDrain();
      randReady = 1'b0;
      cycle();
      m.out_ready = 1'b1;
      cycle();
    end

    repeat (3) cycle();
    if (expQ.size() != 0) failNow("scoreboard_leftover");
    $display("== %0d vectors applied, %0d miscompares ==", nCmp, nFail);
    $finish;
  end

endmodule
